// File: rtl/pixel_dimmer_pkg.sv
// Shared constants, FSM encoding and channel layout for the pixel dimmer.
package pixel_dimmer_pkg;

    localparam int DATA_W   = 32;
    localparam int BRIGHT_W = 8;
    localparam int NUM_CH   = 3;

    // Channel bit positions inside a pixel word
    localparam int PASS_MSB = 31;
    localparam int PASS_LSB = 24;
    localparam int G_MSB    = 23;
    localparam int G_LSB    = 16;
    localparam int R_MSB    = 15;
    localparam int R_LSB    = 8;
    localparam int B_MSB    = 7;
    localparam int B_LSB    = 0;

    typedef enum logic [1:0] {
        ST_MANUAL    = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2
    } fade_state_t;

    // Low bit of colour channel idx (0 = B, 1 = R, 2 = G)
    function automatic int ch_lsb(input int idx);
        case (idx)
            0:       return B_LSB;
            1:       return R_LSB;
            default: return G_LSB;
        endcase
    endfunction

endpackage

// File: rtl/pixel_dimmer_if.sv
// Pixel word stream between the generator, the dimmer and the LED driver.
interface pixel_dimmer_if;
    import pixel_dimmer_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_write_en;
    logic [DATA_W-1:0] out_data;
    logic              out_write_en;
    logic              frame_start;

    // Dimmer side: consumes the raw stream, produces the scaled stream
    modport slave (
        input  in_data,
        input  in_write_en,
        output out_data,
        output out_write_en,
        output frame_start
    );

    // Upstream/downstream side: supplies raw words, observes scaled words
    modport master (
        output in_data,
        output in_write_en,
        input  out_data,
        input  out_write_en,
        input  frame_start
    );

endinterface

// File: rtl/pixel_dimmer_channel_scale.sv
// One colour channel multiplier: out = (chan * (fb + 1)) >> 8, registered.
module channel_scale
    import pixel_dimmer_pkg::*;
(
    input  logic                axi_clock,
    input  logic                axi_reset,
    input  logic                i_en,
    input  logic [BRIGHT_W-1:0] i_chan,
    input  logic [BRIGHT_W-1:0] i_fb,
    output logic [BRIGHT_W-1:0] o_chan
);

    localparam int PROD_W = 2 * BRIGHT_W + 1;

    logic [BRIGHT_W:0]   w_fb_plus;
    logic [PROD_W-1:0]   w_prod;
    logic [BRIGHT_W-1:0] r_chan;

    // fb+1 keeps fb=255 an exact identity and fb=0 a full blank
    assign w_fb_plus = {1'b0, i_fb} + {{BRIGHT_W{1'b0}}, 1'b1};
    assign w_prod    = PROD_W'(i_chan) * PROD_W'(w_fb_plus);

    // Register the product's middle byte when a word is moving through
    always_ff @(posedge axi_clock or posedge axi_reset) begin
        if (axi_reset) begin
            r_chan <= '0;
        end else if (i_en) begin
            r_chan <= BRIGHT_W'(w_prod >> BRIGHT_W);
        end
    end

    assign o_chan = r_chan;

endmodule

// File: rtl/pixel_dimmer.sv
// Global brightness / breathing-fade stage on the pixel word stream.
// Two-stage pipeline: stage 1 captures the word and the frame brightness,
// stage 2 holds the scaled channels. A fade FSM drives the level.
module pixel_dimmer
    import pixel_dimmer_pkg::*;
#(
    parameter int C_PIXELS    = 12,
    parameter int C_FADE_TICK = 488281
) (
    input  logic                axi_clock,
    input  logic                axi_reset,
    pixel_dimmer_if.slave       bus,
    input  logic [BRIGHT_W-1:0] brightness_target,
    input  logic                fade_enable,
    output logic [BRIGHT_W-1:0] level
);

    localparam int IDX_W  = (C_PIXELS > 1) ? $clog2(C_PIXELS) : 1;
    localparam int TICK_W = (C_FADE_TICK > 1) ? $clog2(C_FADE_TICK) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(C_PIXELS - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(C_FADE_TICK - 1);

    // Fade FSM state
    fade_state_t         r_state;
    logic [BRIGHT_W-1:0] r_level;
    logic [TICK_W-1:0]   r_tick;
    logic                w_tick;
    logic [BRIGHT_W:0]   w_level_inc;

    // Stream pipeline
    logic [IDX_W-1:0]    r_index;
    logic                w_first;
    logic [BRIGHT_W-1:0] w_fb_use;
    logic [BRIGHT_W-1:0] r_fb;
    logic                r_s1_valid;
    logic                r_s1_first;
    logic [DATA_W-1:0]   r_s1_data;
    logic                r_out_valid;
    logic                r_out_first;
    logic [7:0]          r_out_pass;
    logic [BRIGHT_W-1:0] w_chan_out [NUM_CH];
    logic [DATA_W-1:0]   w_out_data;

    assign w_tick      = (r_state != ST_MANUAL) && (r_tick == TICK_LAST);
    assign w_level_inc = {1'b0, r_level} + {{BRIGHT_W{1'b0}}, 1'b1};

    // Fade FSM: track target in MANUAL, triangle between 0 and target otherwise.
    // Entering RAMP_UP keeps the current level so a ramp starts from where
    // the level already is; leaving a ramp reloads the target immediately.
    always_ff @(posedge axi_clock or posedge axi_reset) begin
        if (axi_reset) begin
            r_state <= ST_MANUAL;
            r_level <= '0;
            r_tick  <= '0;
        end else begin
            case (r_state)
                ST_MANUAL: begin
                    r_tick <= '0;
                    if (fade_enable) begin
                        r_state <= ST_RAMP_UP;
                    end else begin
                        r_level <= brightness_target;
                    end
                end
                ST_RAMP_UP: begin
                    if (!fade_enable) begin
                        r_state <= ST_MANUAL;
                        r_level <= brightness_target;
                        r_tick  <= '0;
                    end else begin
                        r_tick <= w_tick ? '0 : r_tick + TICK_W'(1);
                        if (w_tick) begin
                            // Reaching or overshooting the peak clamps and turns round
                            if (w_level_inc >= {1'b0, brightness_target}) begin
                                r_level <= brightness_target;
                                r_state <= ST_RAMP_DOWN;
                            end else begin
                                r_level <= w_level_inc[BRIGHT_W-1:0];
                            end
                        end
                    end
                end
                ST_RAMP_DOWN: begin
                    if (!fade_enable) begin
                        r_state <= ST_MANUAL;
                        r_level <= brightness_target;
                        r_tick  <= '0;
                    end else begin
                        r_tick <= w_tick ? '0 : r_tick + TICK_W'(1);
                        if (w_tick) begin
                            // Level 0 here only happens with a zero target: just turn round
                            if (r_level == '0) begin
                                r_state <= ST_RAMP_UP;
                            end else begin
                                r_level <= r_level - BRIGHT_W'(1);
                                if (r_level == BRIGHT_W'(1)) begin
                                    r_state <= ST_RAMP_UP;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_MANUAL;
                    r_tick  <= '0;
                end
            endcase
        end
    end

    assign level = r_level;

    // Frame brightness is taken from the live level for pixel 0 itself
    assign w_first  = (r_index == '0);
    assign w_fb_use = w_first ? r_level : r_fb;

    // Pixel index: counts accepted words, wraps without an idle cycle
    always_ff @(posedge axi_clock or posedge axi_reset) begin
        if (axi_reset) begin
            r_index <= '0;
        end else if (bus.in_write_en) begin
            r_index <= (r_index == LAST_IDX) ? '0 : r_index + IDX_W'(1);
        end
    end

    // Stage 1: capture word, frame-start flag and the frame brightness
    always_ff @(posedge axi_clock or posedge axi_reset) begin
        if (axi_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_data  <= '0;
            r_fb       <= '0;
        end else begin
            r_s1_valid <= bus.in_write_en;
            if (bus.in_write_en) begin
                r_s1_data  <= bus.in_data;
                r_s1_first <= w_first;
                r_fb       <= w_fb_use;
            end
        end
    end

    // Stage 2: the three colour multipliers
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            localparam int LSB = ch_lsb(gi);

            channel_scale u_scale (
                .axi_clock (axi_clock),
                .axi_reset (axi_reset),
                .i_en      (r_s1_valid),
                .i_chan    (r_s1_data[LSB +: BRIGHT_W]),
                .i_fb      (r_fb),
                .o_chan    (w_chan_out[gi])
            );

            assign w_out_data[LSB +: BRIGHT_W] = w_chan_out[gi];
        end
    endgenerate

    // Stage 2: strobe, frame marker and untouched top byte alongside the products
    always_ff @(posedge axi_clock or posedge axi_reset) begin
        if (axi_reset) begin
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_pass  <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_first <= r_s1_valid & r_s1_first;
            if (r_s1_valid) begin
                r_out_pass <= r_s1_data[PASS_MSB:PASS_LSB];
            end
        end
    end

    assign w_out_data[PASS_MSB:PASS_LSB] = r_out_pass;

    assign bus.out_data     = w_out_data;
    assign bus.out_write_en = r_out_valid;
    assign bus.frame_start  = r_out_first;

endmodule

// File: tb/tb_pixel_dimmer.sv
// Self-checking bench for pixel_dimmer: scoreboard of expected output words
// built from channel arithmetic, plus triangle-wave check of the fade level.
module tb_pixel_dimmer;

    localparam int NPIX = 12;
    localparam int TICK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] target = 8'd0;
    logic       fade = 1'b0;
    logic [7:0] level;

    pixel_dimmer_if bus_if ();

    pixel_dimmer #(
        .C_PIXELS    (NPIX),
        .C_FADE_TICK (TICK)
    ) dut (
        .axi_clock         (clk),
        .axi_reset         (rst),
        .bus               (bus_if),
        .brightness_target (target),
        .fade_enable       (fade),
        .level             (level)
    );

    always #4 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_fs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        first;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // In manual mode the level simply follows the target one cycle late
    logic [7:0] m_level;
    always @(posedge clk or posedge rst) begin
        if (rst)       m_level <= 8'd0;
        else if (!fade) m_level <= target;
    end

    int m_index = 0;
    int m_fb = 0;

    function automatic logic [31:0] scale_word(input logic [31:0] w, input int fb);
        logic [31:0] r;
        r = w & 32'hFF00_0000;
        for (int c = 0; c < 3; c++) begin
            int ch;
            int v;
            ch = int'((w >> (8 * c)) & 32'hFF);
            v  = (ch * (fb + 1)) / 256;
            r  = r | (32'(v) << (8 * c));
        end
        return r;
    endfunction

    function automatic int tri_level(input int n, input int peak);
        int m;
        m = n % (2 * peak);
        return (m <= peak) ? m : (2 * peak - m);
    endfunction

    task automatic send_word(input logic [31:0] w);
        exp_t e;
        @(negedge clk);
        bus_if.in_data     = w;
        bus_if.in_write_en = 1'b1;
        if (m_index == 0) m_fb = int'(m_level);
        e.due   = cyc + 2;
        e.data  = scale_word(w, m_fb);
        e.first = (m_index == 0);
        q.push_back(e);
        $display("in  cyc=%0d idx=%0d word=0x%08h fb=%0d exp=0x%08h", cyc, m_index, w, m_fb, e.data);
        m_index = (m_index + 1) % NPIX;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_if.in_write_en = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.in_write_en = 1'b0;
        q.delete();
        m_index = 0;
        m_fb = 0;
        #1;
        chk("rst_out_data", bus_if.out_data, 32'd0);
        chk("rst_out_we", {31'd0, bus_if.out_write_en}, 32'd0);
        chk("rst_frame_start", {31'd0, bus_if.frame_start}, 32'd0);
        chk("rst_level", {24'd0, level}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
    endtask

    // Output monitor: every strobe must match the oldest expected word exactly on time
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            mon_e = q.pop_front();
            chk("out_we", {31'd0, bus_if.out_write_en}, 32'd1);
            chk("out_data", bus_if.out_data, mon_e.data);
            chk("frame_start", {31'd0, bus_if.frame_start}, {31'd0, mon_e.first});
            $display("out cyc=%0d data=0x%08h fs=%0b", cyc, bus_if.out_data, bus_if.frame_start);
        end else if (bus_if.out_write_en) begin
            chk("spurious_we", {31'd0, bus_if.out_write_en}, 32'd0);
        end
        if (bus_if.out_write_en && bus_if.frame_start) n_fs++;
    end

    // ---------------- stimulus ----------------
    initial begin
        int fs_before;
        bus_if.in_data     = 32'd0;
        bus_if.in_write_en = 1'b0;

        // Manual identity
        target = 8'd255;
        do_reset();
        repeat (12) send_word(32'h00A0_50FF);
        idle(3);

        // Manual scale by 128/256 (new frame after the 12 identity words)
        target = 8'd127;
        idle(2);
        send_word(32'hABFF_8001);
        idle(3);

        // Target 0 blanks all colour channels
        target = 8'd0;
        do_reset();
        send_word(32'hABFF_8001);
        idle(3);

        // Frame latching: target change mid-frame only affects the next frame
        target = 8'd255;
        do_reset();
        for (int i = 0; i < 6; i++) send_word(32'h11C0_80FF + 32'(i));
        @(negedge clk);
        bus_if.in_write_en = 1'b0;
        target = 8'd63;
        for (int i = 6; i < 24; i++) send_word(32'h22F0_8040 + 32'(i));
        idle(3);

        // Back-to-back wrap: 25 words give frame starts at words 0, 12, 24
        target = 8'd200;
        do_reset();
        fs_before = n_fs;
        for (int i = 0; i < 25; i++) send_word($urandom);
        idle(3);
        chk("fs_count", 32'(n_fs - fs_before), 32'd3);

        // Randomised stream: gaps and target changes
        for (int i = 0; i < 120; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                @(negedge clk);
                bus_if.in_write_en = 1'b0;
                target = 8'($urandom);
            end else if (r < 3) begin
                idle(1);
            end else begin
                send_word($urandom);
            end
        end
        idle(3);

        // Reset mid-stream: one word in stage 1, a second on the bus
        target = 8'd255;
        idle(2);
        send_word(32'h0102_0304);
        @(negedge clk);
        bus_if.in_data     = 32'h0506_0708;
        bus_if.in_write_en = 1'b1;
        rst = 1'b1;
        q.delete();
        m_index = 0;
        m_fb = 0;
        #1;
        chk("midrst_we", {31'd0, bus_if.out_write_en}, 32'd0);
        @(negedge clk);
        bus_if.in_write_en = 1'b0;
        rst = 1'b0;
        idle(3);
        send_word(32'h0A0B_0C0D);
        send_word(32'h0E0F_1011);
        idle(3);

        // Fade: from level 0, target 3, ramp period TICK cycles per step
        target = 8'd0;
        idle(3);
        @(negedge clk);
        target = 8'd3;
        fade = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("fade_level", {24'd0, level}, 32'(tri_level(k / TICK, 3)));
            $display("fade k=%0d level=%0d", k, level);
        end
        fade = 1'b0;
        @(negedge clk);
        chk("fade_exit_level", {24'd0, level}, 32'd3);

        idle(4);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_dimmer.md
# pixel_dimmer

Global brightness and breathing-fade stage inserted between `axi_generator` and `neopixel_control` on the 125 MHz control clock. It consumes the generator's 32-bit pixel word stream and scales each colour channel by a frame-latched brightness level. It then forwards the scaled stream with identical write strobes to `neopixel_control`. An internal fade state machine can ramp the level up and down autonomously ("breathing") or track a static target.

## Interface
- `C_PIXELS`, 12: words per frame; the pixel index wraps at this count.
- `C_FADE_TICK`, 488281: clock cycles per one-step brightness change (about 1 s full-scale ramp at 125 MHz); must be ≥1.
- `axi_clock`  in  1  sole clock.
- `axi_reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  32  pixel word: [31:24] passthrough, [23:16] G, [15:8] R, [7:0] B.
- `in_write_en`  in  1  `in_data` valid this cycle; may be asserted on consecutive cycles.
- `brightness_target`  in  8  static level (manual mode) or peak level (fade mode).
- `fade_enable`  in  1  1 = breathing between 0 and target; 0 = track target.
- `out_data`  out  32  scaled pixel word.
- `out_write_en`  out  1  `out_data` valid.
- `frame_start`  out  1  high with `out_write_en` for pixel index 0.
- `level`  out  8  current internal brightness.

## Operation
- No backpressure: every accepted input word produces exactly one output word, in order.
- Pixel index counter:
  - 0..C_PIXELS-1; increments on each `in_write_en`; wraps to 0 after C_PIXELS-1.
- Frame brightness `fb`:
  - Loaded from `level` when a word with index 0 is accepted.
  - Every pixel of a frame uses the same `fb`.
  - A level change mid-frame takes effect at the next frame.
- Channel scaling, per channel c:
  - out = (c × (fb+1)) >> 8, computed as a 17-bit product and taking bits [15:8].
  - fb=255 gives identity; fb=0 gives 0.
  - [31:24] passes through unchanged.
- Fade FSM states: MANUAL, RAMP_UP, RAMP_DOWN.
  - MANUAL: `level` ← `brightness_target` every cycle. `fade_enable`=1 → RAMP_UP, tick counter cleared.
  - RAMP_UP: on each tick, `level`+1. When `level` ≥ target → clamp `level` = target → RAMP_DOWN.
  - RAMP_DOWN: on each tick, `level`−1. When `level` = 0 → RAMP_UP.
  - In either ramp state, `fade_enable`=0 → MANUAL next cycle. This takes priority over a coincident tick.
  - If target drops below `level` during RAMP_UP, clamp to target on the next tick and enter RAMP_DOWN.
  - If target = 0, the FSM alternates states on each tick with `level` held at 0.
- Tick counter:
  - 0..C_FADE_TICK-1; tick pulses at the terminal count.
  - Runs only in the ramp states; held at 0 in MANUAL.

## Timing
- Latency: input word at cycle N → `out_write_en`/`out_data` at N+2 (stage 1 registers data and `fb`; stage 2 registers the product).
- Throughput: one word per cycle sustained.
- `fb` is latched in the same cycle as the index-0 word is accepted and is applied to that word.
- `level` updates one cycle after a tick or a MANUAL target change.
- Reset values (asynchronous assert):
  - Outputs: `out_data`=0, `out_write_en`=0, `frame_start`=0, `level`=0.
  - Internal: state MANUAL, index 0, `fb` 0, tick counter 0.
- Reset mid-operation: in-flight pipeline words are discarded, no output strobe follows, and the index restarts at 0. The first post-reset word is treated as frame start.
- Index wrap on a back-to-back C_PIXELS-1 → 0 transition needs no idle cycle between frames.

## Structure
- Shared package constants:
  - Channel bit positions: G_MSB/LSB 23:16, R 15:8, B 7:0.
  - FSM state encoding: MANUAL=2'd0, RAMP_UP=2'd1, RAMP_DOWN=2'd2.
  - Brightness width 8.
- One sub-module, `channel_scale`, is instantiated three times: an 8-bit channel and 8-bit fb in, registered 8-bit result out (stage 2).
- Top instantiates `pixel_dimmer` between `axi_generator` and `neopixel_control`, using the same `C_PIXELS`.
- Expected RTL: about 200 lines.

## Test plan
- Manual identity: target=255, fade=0, 12 words 0x00A0_50FF → 12 outputs 0x00A0_50FF, each 2 cycles after input; `frame_start` on the first only.
- Manual scale: target=127, word 0xAB_FF_80_01 → 0xAB_7F_40_00. Target=0 → 0xAB_00_00_00.
- Frame latching: target changes 255→63 after pixel 5 of a frame → pixels 6–11 still unscaled; the next frame is scaled by 64/256.
- Fade: C_FADE_TICK=4, target=3, fade=1 → `level` steps 0,1,2,3,2,1,0,1… every 4 cycles. Deassert fade mid-ramp → `level`=3 one cycle later.
- Wrap/back-to-back: 25 consecutive words with C_PIXELS=12 → `frame_start` on output words 0, 12 and 24; no dropped or duplicated strobes.
- Reset mid-stream: assert `axi_reset` while 2 words are in flight → no output strobes from them; the next input is treated as index 0 with `frame_start`.
